seven_seg_scan_driver: RTL and testbench

Time-multiplexed driver for a bank of NUM_DIGITS common-anode seven-segment digits sharing one segment bus. It is the parametrised successor of the single-digit hex decoder. Additions over the decoder:
- a refresh prescaler and a digit scan counter;
- a frame-synchronous shadow register, so a new value never tears mid-frame;
- per-digit blanking.
It sits between the game's score/reaction-time logic and the board display pins.

---
 rtl/seven_seg_pkg.sv | 13 +
 rtl/hex_to_seg.sv | 12 +
 rtl/seven_seg_scan_driver.sv | 66 ++++++
 tb/tb_seven_seg_scan_driver.sv | 125 ++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared segment constants, decode table and index-width helper for the scan driver.
package seven_seg_pkg;
  localparam logic [0:6] SEG_BLANK = 7'b1111111;
  localparam logic [0:6] SEG_LUT [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
  function automatic int idx_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/hex_to_seg.sv
// hex_to_seg: active-low a..g decoder; any nibble not matching a table entry (e.g. unknown) decodes to blank.
module hex_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [0:6] o_seg
);
  always_comb begin
    o_seg = SEG_BLANK;
    for (int i = 0; i < 16; i++) if (i_hex == 4'(i)) o_seg = SEG_LUT[i];
  end
endmodule

// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: time-multiplexed common-anode driver with frame-synchronous shadow register.
// Define SEVEN_SEG_LEADING_ZERO_BLANK_EN to blank digits above the most significant nonzero nibble.
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [0:6]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);
  localparam int PW = idx_width(REFRESH_DIV);
  localparam int IW = idx_width(NUM_DIGITS);
  logic [PW-1:0]           r_presc;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic [4*NUM_DIGITS-1:0] r_staging;
  logic                    r_pending;
  logic                    w_tick;
  logic                    w_wrap;
  logic                    w_show;
  logic [3:0]              w_nib;
  logic [0:6]              w_dec;
  assign w_tick = r_presc == PW'(REFRESH_DIV - 1);
  assign w_wrap = w_tick && r_idx == IW'(NUM_DIGITS - 1);
  assign w_nib  = r_shadow[{r_idx, 2'b00} +: 4];
  hex_to_seg u_dec (.i_hex(w_nib), .o_seg(w_dec));
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  logic [IW-1:0] w_msd;
  always_comb begin
    w_msd = '0;
    for (int i = 1; i < NUM_DIGITS; i++) if (r_shadow[4*i +: 4] != 4'h0) w_msd = IW'(i);
  end
  assign w_show = digit_en[r_idx] && r_idx <= w_msd;
`else
  assign w_show = digit_en[r_idx];
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc    <= '0;
      r_idx      <= '0;
      r_shadow   <= '0;
      r_staging  <= '0;
      r_pending  <= 1'b0;
      an         <= '1;
      seg        <= SEG_BLANK;
      frame_done <= 1'b0;
    end else begin
      r_presc    <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick) r_idx <= w_wrap ? '0 : r_idx + 1'b1;
      frame_done <= w_wrap;
      if (load) r_staging <= value;
      // a load on the wrap edge bypasses staging so nothing is left pending
      r_pending  <= w_wrap ? 1'b0 : (load | r_pending);
      if (w_wrap && (load || r_pending)) r_shadow <= load ? value : r_staging;
      an         <= w_show ? ~(NUM_DIGITS'(1) << r_idx) : '1;
      seg        <= w_show ? w_dec : SEG_BLANK;
    end
  end
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb_seven_seg_scan_driver: directed and random stimulus checked against a cycle-count reference model.
module tb_seven_seg_scan_driver;
  localparam int ND = 4;
  localparam int RD = 4;
  localparam int FR = ND * RD;
  logic        clk = 0;
  logic        rst = 0;
  logic        load = 0;
  logic [15:0] value = '0;
  logic [3:0]  digit_en = 4'hF;
  logic [0:6]  seg;
  logic [3:0]  an;
  logic        frame_done;
  int          errs = 0;
  int          checks = 0;
  int          t = 0;
  logic [15:0] sh_m = '0;
  logic [15:0] st_m = '0;
  logic        pend_m = 0;
  logic [3:0]  en_cur = 4'hF;
  logic [0:6]  lut [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
  seven_seg_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
    .clk(clk), .rst(rst), .value(value), .load(load), .digit_en(digit_en),
    .seg(seg), .an(an), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
    end
  endtask
  // digit i is lit during edges t with (t / RD) % ND == i; outputs show it one edge later
  task automatic step(input logic ld, input logic [15:0] v);
    int         i;
    logic       show;
    logic [3:0] e_an;
    logic [0:6] e_seg;
    load = ld;
    value = v;
    digit_en = en_cur;
    i = (t / RD) % ND;
    show = en_cur[i];
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    if (i != 0 && (sh_m >> (4 * i)) == 0) show = 0;
`endif
    e_an = show ? ~(4'b1 << i) : 4'hF;
    e_seg = show ? lut[4'(sh_m >> (4 * i))] : 7'b1111111;
    @(posedge clk);
    #1;
    chk("an", 32'(an), 32'(e_an));
    chk("seg", 32'(seg), 32'(e_seg));
    chk("frame_done", 32'(frame_done), 32'(t % FR == FR - 1));
    if (t % FR == FR - 1) begin
      if (ld) sh_m = v;
      else if (pend_m) sh_m = st_m;
      pend_m = 0;
    end else if (ld) begin
      st_m = v;
      pend_m = 1;
    end
    t++;
    load = 0;
  endtask
  task automatic run_to(input int phase);
    for (int k = 0; k < FR && t % FR != phase; k++) step(0, 16'h0);
  endtask
  task automatic run(input int n);
    for (int k = 0; k < n; k++) step(0, 16'h0);
  endtask
  task automatic do_reset();
    load = 0;
    rst = 1;
    #1;
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_fd", 32'(frame_done), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an_hold", 32'(an), 32'hF);
    chk("rst_seg_hold", 32'(seg), 32'h7F);
    rst = 0;
    t = 0;
    sh_m = '0;
    st_m = '0;
    pend_m = 0;
  endtask
  initial begin
    #2;
    do_reset();
    run(5);
    step(1, 16'h1234);
    run(2 * FR + 3);
    run_to(8);
    step(1, 16'hABCD);
    run(2 * FR);
    run_to(FR - 1);
    step(1, 16'h00FF);
    run(FR + 4);
    en_cur = 4'b1011;
    run(FR + 2);
    en_cur = 4'hF;
    step(1, 16'h0042);
    run(2 * FR);
    run_to(13);
    step(1, 16'h9999);
    run(1);
    do_reset();
    run(2 * FR);
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 15) == 0) en_cur = 4'($urandom);
      else if ($urandom_range(0, 15) == 0) en_cur = 4'hF;
      if ($urandom_range(0, 7) == 0) step(1, 16'($urandom));
      else step(0, 16'($urandom));
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
